// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full_adder cell, a registered carry and operand/result shift registers.
// Latency: result valid WIDTH cycles after the accept edge; next operands accepted one cycle after the result handshake.
// Backpressure: in_ready low outside IDLE; result and out_valid are held while out_ready is low.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_bit;
          if (cnt == LAST) begin
            // Final bit: publish the result directly so it is valid on entry to DONE.
            cnt       <= '0;
            sum       <= {s_bit, sum_sh[WIDTH-1:1]};
            cout      <= c_bit;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8 (directed) and WIDTH=2 (exhaustive).
module tb_bit_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic       rst8, iv8, ir8, cin8, ov8, or8, co8, busy8;
  logic [7:0] a8, b8, s8;
  logic       rst2, iv2, ir2, cin2, ov2, or2, co2, busy2;
  logic [1:0] a2, b2, s2;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(busy8)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
    .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .busy(busy2)
  );

  logic [8:0] q8[$];
  logic [2:0] q2[$];

  // Monitors sample at negedge; inputs change at posedge+1.
  int  acc8 = 0, busy_n8 = 0;
  logic prev_ov8 = 1'b0;
  always @(negedge clk) begin
    if (rst8) begin
      prev_ov8 = 1'b0;
      busy_n8  = 0;
    end else begin
      if (iv8 && ir8) begin
        q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
        acc8    = cyc + 1;
        busy_n8 = 0;
      end
      if (busy8) busy_n8++;
      if (ov8 && !prev_ov8) begin
        check("lat8", cyc - acc8, 8);
        check("busy8_len", busy_n8, 8);
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) check("q8_unexpected_out", q8.size(), 1);
        else check("res8", {co8, s8}, q8.pop_front());
      end
      prev_ov8 = ov8;
    end
  end

  int  acc2 = 0;
  logic prev_ov2 = 1'b0;
  always @(negedge clk) begin
    if (rst2) begin
      prev_ov2 = 1'b0;
    end else begin
      if (iv2 && ir2) begin
        q2.push_back({1'b0, a2} + {1'b0, b2} + {2'd0, cin2});
        acc2 = cyc + 1;
      end
      if (ov2 && !prev_ov2) check("lat2", cyc - acc2, 2);
      if (ov2 && or2) begin
        if (q2.size() == 0) check("q2_unexpected_out", q2.size(), 1);
        else check("res2", {co2, s2}, q2.pop_front());
      end
      prev_ov2 = ov2;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    iv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    for (int i = 0; i < 50 && !ir8; i++) tick(1);
    if (!ir8) check("send8_timeout", ir8, 1);
    tick(1);
    iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
  endtask

  task automatic wait_done8;
    for (int i = 0; i < 100 && (q8.size() != 0 || ov8); i++) tick(1);
    check("drain8", q8.size(), 0);
  endtask

  task automatic send2(input logic [1:0] a, input logic [1:0] b, input logic c);
    iv2 = 1'b1; a2 = a; b2 = b; cin2 = c;
    for (int i = 0; i < 50 && !ir2; i++) tick(1);
    if (!ir2) check("send2_timeout", ir2, 1);
    tick(1);
    iv2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_acc, now_acc;
    logic [7:0] ops_a[3];
    logic [7:0] ops_b[3];
    logic       ops_c[3];
    rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8 = 1'b1;
    rst2 = 1'b1; iv2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; or2 = 1'b1;
    tick(2);
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_busy", busy8, 0);
    check("rst_sum", {co8, s8}, 0);
    rst8 = 1'b0; rst2 = 1'b0;
    tick(2);

    send8(8'h5A, 8'h3C, 1'b0);
    wait_done8();
    check("idle_hold", {co8, s8}, 9'h096);
    send8(8'hFF, 8'h01, 1'b0);
    send8(8'hFF, 8'hFF, 1'b1);
    wait_done8();

    // Backpressure: result must hold, and a new request must be ignored.
    or8 = 1'b0;
    send8(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 40 && !ov8; i++) tick(1);
    check("bp_ov_rise", ov8, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin iv8 = 1'b1; a8 = 8'h11; b8 = 8'h11; end
      if (i == 2) iv8 = 1'b0;
      check("bp_ov", ov8, 1);
      check("bp_res", {co8, s8}, 9'h046);
      check("bp_in_ready", ir8, 0);
      tick(1);
    end
    or8 = 1'b1;
    tick(1);
    check("bp_in_ready_after", ir8, 1);
    check("bp_ov_after", ov8, 0);
    wait_done8();

    // Reset in the 3rd RUN cycle discards the operation.
    send8(8'h0F, 8'h01, 1'b0);
    tick(2);
    rst8 = 1'b1;
    q8.delete();
    #1;
    check("mr_out_valid", ov8, 0);
    check("mr_busy", busy8, 0);
    check("mr_in_ready", ir8, 1);
    check("mr_res", {co8, s8}, 0);
    tick(2);
    rst8 = 1'b0;
    tick(12);
    check("mr_no_pulse", ov8, 0);
    send8(8'h01, 8'h02, 1'b0);
    wait_done8();
    check("mr_result", {co8, s8}, 9'h003);

    // Back-to-back with in_valid held high.
    ops_a = '{8'h5A, 8'hFF, 8'hFF};
    ops_b = '{8'h3C, 8'h01, 8'hFF};
    ops_c = '{1'b0, 1'b0, 1'b1};
    prev_acc = 0;
    iv8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a8 = ops_a[k]; b8 = ops_b[k]; cin8 = ops_c[k];
      for (int i = 0; i < 50 && !ir8; i++) tick(1);
      now_acc = cyc + 1;
      if (k > 0) check("b2b_interval", now_acc - prev_acc, 10);
      prev_acc = now_acc;
      tick(1);
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    end
    for (int i = 0; i < 50 && !ir8; i++) tick(1);
    iv8 = 1'b0;
    wait_done8();

    // WIDTH=2 exhaustive sweep.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      send2(v[1:0], v[3:2], v[4]);
    end
    for (int i = 0; i < 50 && (q2.size() != 0 || ov2); i++) tick(1);
    check("drain2", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
